// File: rtl/pixel_write_sink.sv
// pixel_write_sink: queues on-screen pixel plots and streams them to a frame
// memory over a valid/ready write port. Also performs full-frame colour fills
// and keeps clip/overflow statistics.
module pixel_write_sink #(
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SCREEN_H   = 240,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [8:0]  vgaInX,
    input  logic [7:0]  vgaInY,
    input  logic [2:0]  vgaInColour,
    input  logic        clearScreen,
    input  logic [2:0]  clearColour,
    output logic        plotReady,
    output logic [16:0] memAddress,
    output logic [2:0]  memData,
    output logic        memWrite,
    input  logic        memReady,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  clipCount
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [8:0] ScreenW = 9'(SCREEN_W);
    localparam logic [7:0] ScreenH = 8'(SCREEN_H);
    localparam logic [16:0] LastAddr = 17'(SCREEN_W * SCREEN_H - 1);
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StDrain, StClear} stateT;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } entryT;

    stateT           state;
    entryT           fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [PtrW-1:0] headIdx;
    logic [CntW-1:0] count;
    logic            clearPending;
    logic [2:0]      clearColourQ;
    logic            onScreen;
    logic            push;
    logic            pop;
    logic            clrAccept;
    logic            hasNext;
    logic            dropPlot;
    logic            clipPlot;
    entryT           head;

    // Row stride is fixed at 320: y*256 + y*64 + x.
    function automatic logic [16:0] pixelAddr(input entryT e);
        logic [16:0] y17;
        y17 = {9'd0, e.y};
        return (y17 << 8) + (y17 << 6) + {8'd0, e.x};
    endfunction

    // Handshake decode, queue head selection and status flags.
    always_comb begin
        onScreen  = (vgaInX < ScreenW) && (vgaInY < ScreenH);
        plotReady = (count != Depth) && (state != StClear) && !clearPending;
        push      = plot && onScreen && plotReady;
        dropPlot  = plot && onScreen && !plotReady;
        clipPlot  = plot && !onScreen;
        // The presented entry stays queued until its write completes.
        pop       = (state == StDrain) && memWrite && memReady;
        clrAccept = clearScreen && (state != StClear) && !clearPending;
        headIdx   = pop ? rdPtr + PtrW'(1) : rdPtr;
        hasNext   = count > (pop ? CntW'(1) : CntW'(0));
        head      = fifoMem[headIdx];
        busy      = (count != '0) || clearPending || (state == StClear);
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= {vgaInX, vgaInY, vgaInColour};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PtrW'(1);
            if (pop)  rdPtr <= rdPtr + PtrW'(1);
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (!push && pop) begin
                count <= count - CntW'(1);
            end
        end
    end

    // Write sequencer with registered memory port, plus clear/overflow/clip state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= StIdle;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memData      <= '0;
            clearPending <= 1'b0;
            clearColourQ <= '0;
            overflow     <= 1'b0;
            clipCount    <= '0;
        end else begin
            if (clrAccept) begin
                clearPending <= 1'b1;
                clearColourQ <= clearColour;
            end
            if (dropPlot) begin
                overflow <= 1'b1;
            end else if (clrAccept) begin
                overflow <= 1'b0;
            end
            if (clipPlot && clipCount != 8'hFF) begin
                clipCount <= clipCount + 8'd1;
            end

            unique case (state)
                StIdle: begin
                    if (count != '0) begin
                        state      <= StDrain;
                        memWrite   <= 1'b1;
                        memAddress <= pixelAddr(head);
                        memData    <= head.colour;
                    end else if (clearPending) begin
                        state        <= StClear;
                        memWrite     <= 1'b1;
                        memAddress   <= '0;
                        memData      <= clearColourQ;
                        clearPending <= 1'b0;
                    end
                end
                StDrain: begin
                    if (!memWrite || memReady) begin
                        if (hasNext) begin
                            memWrite   <= 1'b1;
                            memAddress <= pixelAddr(head);
                            memData    <= head.colour;
                        end else if (clearPending) begin
                            // Queued plots are flushed before the fill starts.
                            state        <= StClear;
                            memWrite     <= 1'b1;
                            memAddress   <= '0;
                            memData      <= clearColourQ;
                            clearPending <= 1'b0;
                        end else begin
                            state    <= StIdle;
                            memWrite <= 1'b0;
                        end
                    end
                end
                StClear: begin
                    if (memReady) begin
                        if (memAddress == LastAddr) begin
                            state    <= StIdle;
                            memWrite <= 1'b0;
                        end else begin
                            memAddress <= memAddress + 17'd1;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    memWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pixel_write_sink;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        plot = 1'b0;
    logic [8:0]  vgaInX = '0;
    logic [7:0]  vgaInY = '0;
    logic [2:0]  vgaInColour = '0;
    logic        clearScreen = 1'b0;
    logic [2:0]  clearColour = '0;
    logic        plotReady;
    logic [16:0] memAddress;
    logic [2:0]  memData;
    logic        memWrite;
    logic        memReady = 1'b0;
    logic        busy;
    logic        overflow;
    logic [7:0]  clipCount;

    int checks = 0;
    int failures = 0;

    // Writes completed by the DUT, in order, as seen by the monitor.
    logic [16:0] wrAddr[$];
    logic [2:0]  wrData[$];
    int          holdViolations = 0;
    logic        prevStall = 1'b0;
    logic [16:0] prevAddr = '0;
    logic [2:0]  prevData = '0;

    always #5 clock = ~clock;

    pixel_write_sink dut (
        .clock       (clock),
        .resetn      (resetn),
        .plot        (plot),
        .vgaInX      (vgaInX),
        .vgaInY      (vgaInY),
        .vgaInColour (vgaInColour),
        .clearScreen (clearScreen),
        .clearColour (clearColour),
        .plotReady   (plotReady),
        .memAddress  (memAddress),
        .memData     (memData),
        .memWrite    (memWrite),
        .memReady    (memReady),
        .busy        (busy),
        .overflow    (overflow),
        .clipCount   (clipCount)
    );

    // Monitor: logs writes that complete at the next rising edge and flags
    // any change of a stalled write.
    initial begin
        forever begin
            @(negedge clock);
            if (!resetn) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall && (memWrite !== 1'b1 || memAddress !== prevAddr ||
                                  memData !== prevData))
                    holdViolations++;
                if (memWrite === 1'b1 && memReady === 1'b1) begin
                    wrAddr.push_back(memAddress);
                    wrData.push_back(memData);
                end
                prevStall = (memWrite === 1'b1) && (memReady === 1'b0);
                prevAddr  = memAddress;
                prevData  = memData;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        plot = 1'b0;
        clearScreen = 1'b0;
        memReady = 1'b0;
        vgaInX = '0;
        vgaInY = '0;
        vgaInColour = '0;
        clearColour = '0;
        step();
        step();
        resetn = 1'b1;
        wrAddr.delete();
        wrData.delete();
        holdViolations = 0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (memWrite !== 1'b0) begin failures++; $display("FAIL reset_memWrite got=%0b want=0", memWrite); end
        checks++; if (memAddress !== 17'd0) begin failures++; $display("FAIL reset_memAddress got=%0d want=0", memAddress); end
        checks++; if (memData !== 3'd0) begin failures++; $display("FAIL reset_memData got=%0d want=0", memData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        checks++; if (clipCount !== 8'd0) begin failures++; $display("FAIL reset_clipCount got=%0d want=0", clipCount); end
        checks++; if (plotReady !== 1'b1) begin failures++; $display("FAIL reset_plotReady got=%0b want=1", plotReady); end
    endtask

    task automatic test_single();
        doReset();
        memReady = 1'b1;
        plot = 1'b1; vgaInX = 9'd10; vgaInY = 8'd5; vgaInColour = 3'd5;
        step();
        plot = 1'b0;
        checks++; if (memWrite !== 1'b0) begin failures++; $display("FAIL single_latency got=%0b want=0", memWrite); end
        step();
        checks++;
        if (memWrite !== 1'b1 || memAddress !== 17'd1610 || memData !== 3'd5) begin
            failures++;
            $display("FAIL single_write got=%0b/%0d/%0d want=1/1610/5", memWrite, memAddress, memData);
        end
        step();
        checks++; if (memWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got=%0b/%0b want=0/0", memWrite, busy); end
        checks++; if (wrAddr.size() != 1) begin failures++; $display("FAIL single_count got=%0d want=1", wrAddr.size()); end
    endtask

    task automatic test_overflow();
        logic expRdy;
        doReset();
        memReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expRdy = (i < 4);
            checks++; if (plotReady !== expRdy) begin failures++; $display("FAIL ovf_ready%0d got=%0b want=%0b", i, plotReady, expRdy); end
            plot = 1'b1; vgaInX = 9'(20 + i); vgaInY = 8'(i); vgaInColour = 3'(i);
            step();
        end
        plot = 1'b0;
        checks++; if (overflow !== 1'b1 || plotReady !== 1'b0) begin failures++; $display("FAIL ovf_flag got=%0b/%0b want=1/0", overflow, plotReady); end
        memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (memWrite !== 1'b1 || memAddress !== 17'(i * 320 + 20 + i) || memData !== 3'(i)) begin
                failures++;
                $display("FAIL ovf_drain%0d got=%0b/%0d/%0d want=1/%0d/%0d", i, memWrite, memAddress, memData, i * 320 + 20 + i, i);
            end
            step();
        end
        checks++; if (memWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ovf_idle got=%0b/%0b want=0/0", memWrite, busy); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
    endtask

    // Runs straight after test_overflow so the fill must clear a set overflow.
    task automatic test_clear();
        int n = 0;
        int readyBad = 0;
        int seqBad = 0;
        wrAddr.delete();
        wrData.delete();
        memReady = 1'b1;
        plot = 1'b1; vgaInX = 9'd1; vgaInY = 8'd1; vgaInColour = 3'd3;
        clearScreen = 1'b1; clearColour = 3'd2;
        step();
        plot = 1'b0; clearScreen = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%0b want=0", overflow); end
        while (busy === 1'b1 && n < 80000) begin
            if (plotReady !== 1'b0) readyBad++;
            // A second request during the fill must be ignored.
            if (n == 500) begin clearScreen = 1'b1; clearColour = 3'd7; end
            else clearScreen = 1'b0;
            step();
            n++;
        end
        clearScreen = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_timeout busy=%0b after %0d cycles want=0", busy, n); end
        checks++; if (readyBad != 0) begin failures++; $display("FAIL clear_plotReady got=%0d cycles high want=0", readyBad); end
        checks++; if (wrAddr.size() != 76801) begin failures++; $display("FAIL clear_count got=%0d want=76801", wrAddr.size()); end
        if (wrAddr.size() == 76801) begin
            checks++;
            if (wrAddr[0] !== 17'd321 || wrData[0] !== 3'd3) begin
                failures++;
                $display("FAIL clear_first got=%0d/%0d want=321/3", wrAddr[0], wrData[0]);
            end
            for (int i = 0; i < 76800; i++)
                if (wrAddr[i + 1] !== 17'(i) || wrData[i + 1] !== 3'd2) seqBad++;
            checks++; if (seqBad != 0) begin failures++; $display("FAIL clear_sequence got=%0d bad writes want=0", seqBad); end
        end
        checks++; if (plotReady !== 1'b1) begin failures++; $display("FAIL clear_ready_after got=%0b want=1", plotReady); end
    endtask

    task automatic test_clip();
        doReset();
        memReady = 1'b1;
        plot = 1'b1; vgaInX = 9'd320; vgaInY = 8'd0; step();
        vgaInX = 9'd0; vgaInY = 8'd240; step();
        plot = 1'b0;
        repeat (5) step();
        checks++; if (clipCount !== 8'd2) begin failures++; $display("FAIL clip_two got=%0d want=2", clipCount); end
        checks++; if (wrAddr.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL clip_nowrite got=%0d/%0b want=0/0", wrAddr.size(), busy); end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                vgaInX = 9'(320 + $urandom_range(0, 191)); vgaInY = 8'($urandom_range(0, 255));
            end else begin
                vgaInX = 9'($urandom_range(0, 511)); vgaInY = 8'(240 + $urandom_range(0, 15));
            end
            vgaInColour = 3'($urandom_range(0, 7));
            plot = 1'b1;
            step();
        end
        plot = 1'b0;
        step();
        checks++; if (clipCount !== 8'd255) begin failures++; $display("FAIL clip_saturate got=%0d want=255", clipCount); end
        checks++; if (wrAddr.size() != 0 || overflow !== 1'b0) begin failures++; $display("FAIL clip_side got=%0d/%0b want=0/0", wrAddr.size(), overflow); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] expA[4];
        logic [2:0]  expD[4];
        int bad = 0;
        doReset();
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vgaInX = 9'($urandom_range(0, 319)); vgaInY = 8'($urandom_range(0, 239));
            vgaInColour = 3'($urandom_range(0, 7));
            expA[i] = 17'(vgaInY * 320 + vgaInX);
            expD[i] = vgaInColour;
            plot = 1'b1;
            step();
        end
        plot = 1'b0;
        for (int k = 0; k < 12; k++) begin
            memReady = (k % 2 == 0);
            step();
        end
        memReady = 1'b0;
        checks++; if (wrAddr.size() != 4) begin failures++; $display("FAIL bp_count got=%0d want=4", wrAddr.size()); end
        if (wrAddr.size() == 4)
            for (int i = 0; i < 4; i++)
                if (wrAddr[i] !== expA[i] || wrData[i] !== expD[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_order got=%0d bad want=0", bad); end
        checks++; if (holdViolations != 0) begin failures++; $display("FAIL bp_hold got=%0d want=0", holdViolations); end
        checks++; if (memWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%0b/%0b want=0/0", memWrite, busy); end
    endtask

    task automatic test_reset_fill();
        int n = 0;
        doReset();
        memReady = 1'b1;
        clearScreen = 1'b1; clearColour = 3'd6;
        step();
        clearScreen = 1'b0;
        while (!(memWrite === 1'b1 && memAddress === 17'd1000) && n < 3000) begin
            step();
            n++;
        end
        checks++; if (memAddress !== 17'd1000) begin failures++; $display("FAIL rst_reach got=%0d want=1000", memAddress); end
        resetn = 1'b0;
        #1;
        checks++;
        if (memWrite !== 1'b0 || busy !== 1'b0 || memAddress !== 17'd0) begin
            failures++;
            $display("FAIL rst_async got=%0b/%0b/%0d want=0/0/0", memWrite, busy, memAddress);
        end
        step();
        step();
        resetn = 1'b1;
        wrAddr.delete();
        wrData.delete();
        repeat (50) step();
        checks++; if (wrAddr.size() != 0 || memWrite !== 1'b0) begin failures++; $display("FAIL rst_nowrite got=%0d/%0b want=0/0", wrAddr.size(), memWrite); end
        checks++; if (plotReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b want=1", plotReady); end
    endtask

    // Model: occupancy = accepted - completed writes; writes must replay
    // accepted plots in order at address y*320+x.
    task automatic test_random();
        logic [16:0] expA[$];
        logic [2:0]  expD[$];
        int accepted = 0;
        int readyBad = 0;
        int bad = 0;
        int n = 0;
        int expClip = 0;
        logic expOverflow = 1'b0;
        logic expRdy;
        int x;
        int y;
        doReset();
        for (int i = 0; i < 400; i++) begin
            expRdy = (accepted - wrAddr.size()) < 4;
            if (plotReady !== expRdy) readyBad++;
            memReady = ($urandom_range(0, 3) != 0);
            x = $urandom_range(0, 339);
            y = $urandom_range(0, 250);
            vgaInX = 9'(x); vgaInY = 8'(y); vgaInColour = 3'($urandom_range(0, 7));
            plot = ($urandom_range(0, 9) < 7);
            if (plot) begin
                if (x >= 320 || y >= 240) begin
                    if (expClip < 255) expClip++;
                end else if (expRdy) begin
                    expA.push_back(17'(y * 320 + x));
                    expD.push_back(vgaInColour);
                    accepted++;
                end else begin
                    expOverflow = 1'b1;
                end
            end
            step();
        end
        plot = 1'b0;
        memReady = 1'b1;
        while (busy === 1'b1 && n < 50) begin step(); n++; end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_drain busy=%0b want=0", busy); end
        checks++; if (readyBad != 0) begin failures++; $display("FAIL rand_plotReady got=%0d bad cycles want=0", readyBad); end
        checks++; if (wrAddr.size() != expA.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", wrAddr.size(), expA.size()); end
        if (wrAddr.size() == expA.size())
            for (int i = 0; i < expA.size(); i++)
                if (wrAddr[i] !== expA[i] || wrData[i] !== expD[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_order got=%0d bad want=0", bad); end
        checks++; if (holdViolations != 0) begin failures++; $display("FAIL rand_hold got=%0d want=0", holdViolations); end
        checks++; if (overflow !== expOverflow) begin failures++; $display("FAIL rand_overflow got=%0b want=%0b", overflow, expOverflow); end
        checks++; if (clipCount !== 8'(expClip)) begin failures++; $display("FAIL rand_clip got=%0d want=%0d", clipCount, expClip); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_clear();
        test_clip();
        test_back_to_back();
        test_reset_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
